// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver. It decodes high-pulse widths into bits and assembles them into
// packed 24-bit LED words. A frame is published only when it is complete and error-free.
module ws2812_rx #(
  parameter int unsigned NUM_LEDS     = 16,
  parameter int unsigned BIT_THRESH   = 8,
  parameter int unsigned MIN_HIGH     = 2,
  parameter int unsigned MAX_HIGH     = 16,
  parameter int unsigned RESET_CYCLES = 600
) (
  input  logic                   hwclk,
  input  logic                   reset,
  input  logic                   din,
  output logic [24*NUM_LEDS-1:0] packed_rgb_data,
  output logic                   frame_valid,
  output logic                   frame_error,
  output logic                   busy
);

  localparam int unsigned NBITS = 24 * NUM_LEDS;
  localparam int unsigned WW    = $clog2(RESET_CYCLES + 1);
  localparam int unsigned IW    = $clog2(NBITS);
  localparam int unsigned LW    = $clog2(NUM_LEDS + 1);

  localparam logic [WW-1:0] RESET_W  = WW'(RESET_CYCLES);
  localparam logic [WW-1:0] THRESH_W = WW'(BIT_THRESH);
  localparam logic [WW-1:0] MIN_W    = WW'(MIN_HIGH);
  localparam logic [WW-1:0] MAX_W    = WW'(MAX_HIGH);
  localparam logic [LW-1:0] LED_FULL = LW'(NUM_LEDS);

  typedef enum logic [1:0] {StSync, StIdle, StHigh, StLow} state_e;

  state_e             state_q, state_d;
  logic               din_meta_q, din_s_q, din_prev_q;
  logic [WW-1:0]      width_q, width_d;
  logic [LW-1:0]      led_q, led_d;
  logic [4:0]         pos_q, pos_d;
  logic               err_q, err_d;
  logic [NBITS-1:0]   shadow_q, shadow_d;
  logic [NBITS-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               error_q, error_d;
  logic [IW-1:0]      bit_idx;

  // LED words land MSB-first in wire order; LED 0 occupies the low 24 bits.
  assign bit_idx = IW'(led_q) * IW'(24) + IW'(5'd23 - pos_q);

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      din_meta_q <= 1'b0;
      din_s_q    <= 1'b0;
      din_prev_q <= 1'b0;
    end else begin
      din_meta_q <= din;
      din_s_q    <= din_meta_q;
      din_prev_q <= din_s_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    led_d    = led_q;
    pos_d    = pos_q;
    err_d    = err_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    unique case (state_q)
      StSync: begin
        if (din_s_q) begin
          width_d = '0;
        end else if (width_q == RESET_W) begin
          state_d = StIdle;
        end else begin
          width_d = width_q + WW'(1);
        end
      end
      StIdle: begin
        // Level start also catches a rise that coincided with the previous frame end.
        if (din_s_q) begin
          state_d = StHigh;
          width_d = din_prev_q ? WW'(2) : WW'(1);
          led_d   = '0;
          pos_d   = '0;
          err_d   = 1'b0;
        end
      end
      StHigh: begin
        if (width_q > MAX_W) begin
          state_d = StSync;
          width_d = '0;
          err_d   = 1'b1;
          error_d = 1'b1;
        end else if (!din_s_q) begin
          state_d = StLow;
          width_d = WW'(1);
          if (width_q < MIN_W) begin
            err_d = 1'b1;
          end else if (led_q != LED_FULL) begin
            shadow_d[bit_idx] = (width_q >= THRESH_W);
            if (pos_q == 5'd23) begin
              pos_d = '0;
              led_d = led_q + LW'(1);
            end else begin
              pos_d = pos_q + 5'd1;
            end
          end
        end else begin
          width_d = width_q + WW'(1);
        end
      end
      StLow: begin
        if (width_q == RESET_W) begin
          state_d = StIdle;
          if (led_q == LED_FULL && !err_q) begin
            data_d  = shadow_q;
            valid_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end else if (din_s_q) begin
          state_d = StHigh;
          width_d = WW'(1);
        end else begin
          width_d = width_q + WW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      state_q  <= StSync;
      width_q  <= '0;
      led_q    <= '0;
      pos_q    <= '0;
      err_q    <= 1'b0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      led_q    <= led_d;
      pos_q    <= pos_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  assign packed_rgb_data = data_q;
  assign frame_valid     = valid_q;
  assign frame_error     = error_q;
  assign busy            = (state_q == StHigh) || (state_q == StLow);

endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: a WS2812 stream generator feeds the receiver; expected frame pulses are
// queued at stimulus time and matched by an independent monitor.
module tb_ws2812_rx;

  localparam int NLED = 16;
  localparam int NB   = 24 * NLED;
  localparam int GAP  = 700;

  typedef struct {
    bit            is_valid;
    logic [NB-1:0] data;
  } exp_t;

  logic          hwclk;
  logic          reset;
  logic          din;
  logic [NB-1:0] packed_rgb_data;
  logic          frame_valid;
  logic          frame_error;
  logic          busy;

  int            checks;
  int            errors;
  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [NB-1:0] prev_data;
  logic [NB-1:0] cur_data;
  logic [NB-1:0] pat;

  ws2812_rx #(
    .NUM_LEDS    (NLED),
    .BIT_THRESH  (8),
    .MIN_HIGH    (2),
    .MAX_HIGH    (16),
    .RESET_CYCLES(600)
  ) dut (
    .hwclk          (hwclk),
    .reset          (reset),
    .din            (din),
    .packed_rgb_data(packed_rgb_data),
    .frame_valid    (frame_valid),
    .frame_error    (frame_error),
    .busy           (busy)
  );

  initial hwclk = 1'b0;
  always #5 hwclk = ~hwclk;

  task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge hwclk);
  endtask

  task automatic push_exp(input bit v, input logic [NB-1:0] d);
    exp_t e;
    e.is_valid = v;
    e.data     = d;
    exp_q.push_back(e);
  endtask

  function automatic logic [NB-1:0] make_pattern(input int sel);
    logic [NB-1:0] p;
    logic [15:0]   mask;
    p    = '0;
    mask = 16'hA5C3;
    for (int i = 0; i < NLED; i++) begin
      case (sel)
        0:       p[24*i +: 24] = mask[i] ? 24'h101010 : 24'h000000;
        1:       p[24*i +: 24] = {8'(i), 8'h5A ^ 8'(i), 8'(~i)};
        2:       p[24*i +: 24] = 24'hF0F00F ^ 24'(i * 24'h010203);
        default: p[24*i +: 24] = 24'h123456 + 24'(i) * 24'h111111;
      endcase
    end
    return p;
  endfunction

  // Wire order: LED 0 first, each word MSB first.
  function automatic logic frame_bit(input logic [NB-1:0] d, input int k);
    int idx;
    idx = 24 * (k / 24) + 23 - (k % 24);
    return d[idx];
  endfunction

  task automatic send_bit(input logic b);
    din = 1'b1;
    cycles(b ? 10 : 5);
    din = 1'b0;
    cycles(b ? 5 : 10);
  endtask

  task automatic send_stream(input logic [NB-1:0] d, input int nbits, input int glitch_at,
                             input logic busy_exp);
    for (int k = 0; k < nbits; k++) begin
      if (k == glitch_at) begin
        din = 1'b1;
        cycles(1);
        din = 1'b0;
        cycles(6);
      end
      send_bit((k < NB) ? frame_bit(d, k) : 1'b1);
      if (k == 10) check("busy mid-stream", NB'(busy), NB'(busy_exp));
    end
    din = 1'b0;
    cycles(GAP);
  endtask

  // Monitor: one sample per cycle, well clear of the active edge.
  initial prev_data = '0;
  always begin
    @(posedge hwclk);
    #2;
    if (!reset) begin
      if (frame_valid || frame_error) begin
        if (frame_valid && frame_error) begin
          checks++;
          errors++;
          $display("FAIL pulse exclusive: valid=%0b error=%0b", frame_valid, frame_error);
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected pulse: valid=%0b error=%0b required none", frame_valid,
                   frame_error);
        end else begin
          mon_e = exp_q.pop_front();
          check("pulse kind (1=valid)", NB'(frame_valid), NB'(mon_e.is_valid));
          check("frame data", packed_rgb_data, mon_e.data);
        end
      end
      if (packed_rgb_data !== prev_data) begin
        checks++;
        if (!frame_valid) begin
          errors++;
          $display("FAIL data stability: got %0h while frame_valid=0, required %0h",
                   packed_rgb_data, prev_data);
        end
      end
    end
    prev_data = packed_rgb_data;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    cur_data = '0;
    din      = 1'b0;
    reset    = 1'b1;
    cycles(3);
    check("reset data", packed_rgb_data, '0);
    check("reset frame_valid", NB'(frame_valid), '0);
    check("reset frame_error", NB'(frame_error), '0);
    check("reset busy", NB'(busy), '0);
    reset = 1'b0;
    cycles(GAP);

    // Loopback pattern from the 16'hA5C3 mask.
    pat = make_pattern(0);
    push_exp(1'b1, pat);
    cur_data = pat;
    send_stream(pat, NB, -1, 1'b1);
    check("led0 word", NB'(packed_rgb_data[23:0]), NB'(24'h101010));
    check("led2 word", NB'(packed_rgb_data[71:48]), NB'(24'h000000));
    check("led15 word", NB'(packed_rgb_data[383:360]), NB'(24'h101010));

    // Short frame: one bit missing.
    push_exp(1'b0, cur_data);
    send_stream(make_pattern(1), NB - 1, -1, 1'b1);

    // Glitch pulse inside an otherwise complete frame.
    push_exp(1'b0, cur_data);
    send_stream(make_pattern(1), NB, 100, 1'b1);

    // Clean frame afterwards.
    pat = make_pattern(1);
    push_exp(1'b1, pat);
    cur_data = pat;
    send_stream(pat, NB, -1, 1'b1);

    // Long frame: 16 trailing bits must be dropped.
    pat = make_pattern(2);
    push_exp(1'b1, pat);
    cur_data = pat;
    send_stream(pat, NB + 16, -1, 1'b1);

    // Stuck high: abort, then a burst before the resync gap must be ignored.
    push_exp(1'b0, cur_data);
    din = 1'b1;
    cycles(20);
    din = 1'b0;
    cycles(100);
    check("busy after stuck high", NB'(busy), '0);
    send_stream(make_pattern(3), 50, -1, 1'b0);
    pat = make_pattern(3);
    push_exp(1'b1, pat);
    cur_data = pat;
    send_stream(pat, NB, -1, 1'b1);

    // Reset in the middle of a frame.
    pat = make_pattern(2);
    for (int k = 0; k < 100; k++) send_bit(frame_bit(pat, k));
    din   = 1'b0;
    reset = 1'b1;
    cycles(2);
    check("mid reset data", packed_rgb_data, '0);
    check("mid reset frame_valid", NB'(frame_valid), '0);
    check("mid reset frame_error", NB'(frame_error), '0);
    check("mid reset busy", NB'(busy), '0);
    reset    = 1'b0;
    cur_data = '0;
    cycles(GAP);
    pat = make_pattern(0);
    push_exp(1'b1, pat);
    cur_data = pat;
    send_stream(pat, NB, -1, 1'b1);

    for (int i = 0; i < 2000 && exp_q.size() > 0; i++) cycles(1);
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing pulse: got none, required %s", mon_e.is_valid ? "valid" : "error");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
